// File: rtl/rx_pkg.sv
// Shared types and defaults for the oversampled serial receivers.
// RX_PARITY_EN (defined in the top build) enables the PARITY state.
package rx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int   DATA_BITS_DEF  = 4;
  localparam int   OVERSAMPLE_DEF = 4;
  localparam logic STOP_BIT_LEVEL = 1'b1;

endpackage

// File: rtl/rx_sync.sv
// Two-flop synchroniser for an idle-high serial line; resets to 1 so
// a reset release never looks like a start-bit falling edge.
module rx_sync (
  input  logic clk,
  input  logic rstn,
  input  logic async_in,
  output logic sync_out
);

  logic meta_q, sync_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= async_in;
      sync_q <= meta_q;
    end
  end

  assign sync_out = sync_q;

endmodule

// File: rtl/rx_frame_ctrl.sv
// Receive frame controller: start detect, mid-bit sampling, stop check and
// a one-entry valid/ready output buffer. RX_PARITY_EN adds an even-parity bit.
//
// state  | meaning
// IDLE   | waiting for a falling edge on the synchronised line
// START  | half a bit, then confirm the start bit is still low
// DATA   | one sample per bit time, shifted in LSB first
// PARITY | even-parity bit sample (RX_PARITY_EN only)
// STOP   | one bit time, then check the stop level and hand off
module rx_frame_ctrl
  import rx_pkg::*;
#(
  parameter int DATA_BITS  = DATA_BITS_DEF,
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
`ifdef RX_PARITY_EN
  output logic                 parity_err,
`endif
  output logic                 busy
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] HALF_TC  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] FULL_TC  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  rx_state_e state_q, state_d;
  logic                 rxs, rxs_dly_q;
  logic [CW-1:0]        clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 overrun_q, overrun_d;
  logic                 tick, sample_data, stop_done, good;
`ifdef RX_PARITY_EN
  logic                 par_bad_q, par_bad_d;
  logic                 parity_err_q, parity_err_d;
`endif

  rx_sync u_sync (
    .clk      (clk),
    .rstn     (rstn),
    .async_in (rx_in),
    .sync_out (rxs)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:   if (rxs_dly_q && !rxs) state_d = START;
        START:  if (tick) state_d = rxs ? IDLE : DATA;
`ifdef RX_PARITY_EN
        DATA:   if (sample_data && bit_cnt_q == LAST_BIT) state_d = PARITY;
`else
        DATA:   if (sample_data && bit_cnt_q == LAST_BIT) state_d = STOP;
`endif
        PARITY: if (tick) state_d = STOP;
        STOP:   if (tick) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // START samples at half a bit; every other state samples after a full bit.
  always_comb begin
    tick        = (state_q == START) ? (clk_cnt_q == HALF_TC) : (clk_cnt_q == FULL_TC);
    sample_data = (state_q == DATA) && tick;
    stop_done   = enable && (state_q == STOP) && tick;
    busy        = (state_q != IDLE);
  end

  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    if (state_d != state_q || state_q == IDLE) begin
      clk_cnt_d = '0;
      bit_cnt_d = '0;
    end else begin
      clk_cnt_d = tick ? '0 : clk_cnt_q + CW'(1);
      if (sample_data) bit_cnt_d = bit_cnt_q + BW'(1);
    end
    if (sample_data) shift_d = (shift_q >> 1) | (DATA_BITS'(rxs) << (DATA_BITS - 1));
  end

  // A new frame may only land in the buffer when it is empty or draining this cycle.
  always_comb begin
`ifdef RX_PARITY_EN
    par_bad_d = par_bad_q;
    if (state_q == PARITY && tick) par_bad_d = (^shift_q) ^ rxs;
    parity_err_d = stop_done && (rxs == STOP_BIT_LEVEL) && par_bad_q;
    good         = stop_done && (rxs == STOP_BIT_LEVEL) && !par_bad_q;
`else
    good         = stop_done && (rxs == STOP_BIT_LEVEL);
`endif
    frame_err_d = stop_done && (rxs != STOP_BIT_LEVEL);
    overrun_d   = good && rx_valid_q && !rx_ready;
    rx_data_d   = rx_data_q;
    rx_valid_d  = rx_valid_q;
    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;
    if (good && !(rx_valid_q && !rx_ready)) begin
      rx_data_d  = shift_q;
      rx_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxs_dly_q   <= 1'b1;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef RX_PARITY_EN
      par_bad_q    <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rxs_dly_q   <= rxs;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef RX_PARITY_EN
      par_bad_q    <= par_bad_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;
`ifdef RX_PARITY_EN
  assign parity_err = parity_err_q;
`endif

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// Directed bench for rx_frame_ctrl (DATA_BITS=4, OVERSAMPLE=4, 10 ns clock).
// With RX_PARITY_EN defined, frames carry an even-parity bit.
module tb_rx_frame_ctrl;

  localparam int DB = 4;
  localparam int OS = 4;
`ifdef RX_PARITY_EN
  localparam int NBITS = 7;
`else
  localparam int NBITS = 6;
`endif
  // rx_valid / pulses become visible this many cycles after the start bit is driven
  localparam int DONE_OFS = OS * NBITS + 1;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic          rx_in = 1'b1;
  logic          rx_ready = 1'b1;
  logic [DB-1:0] rx_data;
  logic          rx_valid, frame_err, overrun, busy;
`ifdef RX_PARITY_EN
  logic          parity_err;
`endif

  rx_frame_ctrl #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .enable    (enable),
    .rx_in     (rx_in),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
`ifdef RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0, n_errors = 0;
  int   valid_rises = 0, fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, busy_cnt = 0;
  int   rise_cyc = -1, fe_cyc = -1, ov_cyc = -1;
  logic prev_valid = 1'b0;

  // event log sampled shortly after each rising edge
  always @(posedge clk) begin
    #2;
    if (rx_valid && !prev_valid) begin
      valid_rises++;
      rise_cyc = cyc;
    end
    prev_valid = rx_valid;
    if (frame_err) begin fe_cnt++; fe_cyc = cyc; end
    if (overrun)   begin ov_cnt++; ov_cyc = cyc; end
`ifdef RX_PARITY_EN
    if (parity_err) pe_cnt++;
`endif
    if (busy) busy_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] frame(input logic [3:0] d, input logic stop);
`ifdef RX_PARITY_EN
    frame = {9'b0, stop, ^d, d, 1'b0};
`else
    frame = {10'b0, stop, d, 1'b0};
`endif
  endfunction

  // call at a falling edge; returns at the falling edge OS*NBITS cycles later
  task automatic send(input logic [15:0] v, output int c0);
    c0 = cyc;
    for (int k = 0; k < NBITS; k++) begin
      rx_in = v[k];
      repeat (OS) @(negedge clk);
    end
    rx_in = 1'b1;
  endtask

  int c0, c1, b0, vr0, fe0, ov0;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_busy", busy, 0);
    rstn = 1'b1;
    enable = 1'b1;
    repeat (4) @(negedge clk);

    // good frame 0x5 with consumer ready
    send(frame(4'h5, 1'b1), c0);
    @(negedge clk);
    chk("t1_valid_cyc", rise_cyc, c0 + DONE_OFS);
    chk("t1_valid", rx_valid, 1);
    chk("t1_data", rx_data, 4'h5);
    @(negedge clk);
    chk("t1_valid_fall", rx_valid, 0);
    chk("t1_no_ferr", fe_cnt, 0);

    // one-cycle glitch: false start
    repeat (4) @(negedge clk);
    b0 = busy_cnt; vr0 = valid_rises;
    rx_in = 1'b0;
    @(negedge clk);
    rx_in = 1'b1;
    repeat (10) @(negedge clk);
    chk("t2_busy_cycles", busy_cnt - b0, 2);
    chk("t2_no_valid", valid_rises - vr0, 0);
    chk("t2_idle", busy, 0);

    // bad stop bit, then line held low, then a clean 0x3
    vr0 = valid_rises; fe0 = fe_cnt;
    send(frame(4'hA, 1'b0), c0);
    rx_in = 1'b0;
    @(negedge clk);
    chk("t3_ferr", frame_err, 1);
    chk("t3_ferr_cyc", fe_cyc, c0 + DONE_OFS);
    b0 = busy_cnt;
    @(negedge clk);
    chk("t3_ferr_pulse", frame_err, 0);
    repeat (10) @(negedge clk);
    chk("t3_no_retrigger", busy_cnt - b0, 0);
    rx_in = 1'b1;
    repeat (4) @(negedge clk);
    chk("t3_ferr_count", fe_cnt - fe0, 1);
    chk("t3_no_valid", valid_rises - vr0, 0);
    send(frame(4'h3, 1'b1), c0);
    @(negedge clk);
    chk("t3_next_cyc", rise_cyc, c0 + DONE_OFS);
    chk("t3_next_data", rx_data, 4'h3);
    repeat (3) @(negedge clk);

    // overrun: consumer stalled across two frames
    rx_ready = 1'b0;
    send(frame(4'h1, 1'b1), c0);
    @(negedge clk);
    chk("t4_first_data", rx_data, 4'h1);
    repeat (2) @(negedge clk);
    ov0 = ov_cnt;
    send(frame(4'h2, 1'b1), c1);
    @(negedge clk);
    chk("t4_overrun", overrun, 1);
    chk("t4_overrun_cyc", ov_cyc, c1 + DONE_OFS);
    chk("t4_kept_data", rx_data, 4'h1);
    chk("t4_kept_valid", rx_valid, 1);
    @(negedge clk);
    chk("t4_overrun_pulse", overrun, 0);
    chk("t4_overrun_count", ov_cnt - ov0, 1);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("t4_valid_fall", rx_valid, 0);
    repeat (3) @(negedge clk);

    // handshake in the same cycle as completion
    rx_ready = 1'b0;
    send(frame(4'h1, 1'b1), c0);
    repeat (3) @(negedge clk);
    ov0 = ov_cnt;
    send(frame(4'h2, 1'b1), c1);
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    chk("t5_valid", rx_valid, 1);
    chk("t5_data", rx_data, 4'h2);
    chk("t5_no_overrun", overrun, 0);
    @(negedge clk);
    chk("t5_valid_held", rx_valid, 1);
    chk("t5_overrun_count", ov_cnt - ov0, 0);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("t5_valid_fall", rx_valid, 0);
    repeat (3) @(negedge clk);

    // reset during bit 2, buffer full beforehand
    rx_ready = 1'b0;
    send(frame(4'h9, 1'b1), c0);
    @(negedge clk);
    chk("t6_pre_valid", rx_valid, 1);
    vr0 = valid_rises;
    fork
      send(frame(4'h6, 1'b1), c1);
      begin
        repeat (OS * 3 + 2) @(negedge clk);
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_valid", rx_valid, 0);
        chk("t6_rst_data", rx_data, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_ferr", frame_err, 0);
        chk("t6_rst_overrun", overrun, 0);
      end
    join
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    rx_ready = 1'b1;
    repeat (4) @(negedge clk);
    chk("t6_no_partial", valid_rises - vr0, 0);
    send(frame(4'hF, 1'b1), c0);
    @(negedge clk);
    chk("t6_fresh_cyc", rise_cyc, c0 + DONE_OFS);
    chk("t6_fresh_data", rx_data, 4'hF);
    repeat (3) @(negedge clk);

    // enable dropped mid-frame
    vr0 = valid_rises; fe0 = fe_cnt; ov0 = ov_cnt;
    fork
      send(frame(4'h6, 1'b1), c0);
      begin
        repeat (10) @(negedge clk);
        chk("t7_busy_before", busy, 1);
        enable = 1'b0;
        @(negedge clk);
        chk("t7_abort", busy, 0);
      end
    join
    repeat (2) @(negedge clk);
    enable = 1'b1;
    repeat (4) @(negedge clk);
    chk("t7_no_valid", valid_rises - vr0, 0);
    chk("t7_no_ferr", fe_cnt - fe0, 0);
    chk("t7_no_overrun", ov_cnt - ov0, 0);

`ifdef RX_PARITY_EN
    // 0x7 needs parity 1; send 0
    vr0 = valid_rises;
    send({9'b0, 1'b1, 1'b0, 4'h7, 1'b0}, c0);
    @(negedge clk);
    chk("t8_parity_err", parity_err, 1);
    chk("t8_no_ferr", frame_err, 0);
    @(negedge clk);
    chk("t8_parity_pulse", pe_cnt, 1);
    chk("t8_no_valid", valid_rises - vr0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
